// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: receive-side stream from the PS/2 receiver to the decoder.
//   data_out    byte at the FIFO head (first-word fall-through)
//   data_valid  FIFO not empty
//   data_ready  consumer accepts data_out this cycle
//   fifo_count  frames currently buffered
//   err_stb     one-cycle error strobe
//   err_code    0 parity, 1 framing, 2 timeout, 3 overflow (valid with err_stb)
// master = receiver side, slave = consumer side.
interface ps2_rx_fifo_if #(
  parameter int CNT_W = 3
);
  logic [7:0]       data_out;
  logic             data_valid;
  logic             data_ready;
  logic [CNT_W-1:0] fifo_count;
  logic             err_stb;
  logic [1:0]       err_code;

  modport master (
    output data_out, data_valid, fifo_count, err_stb, err_code,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, fifo_count, err_stb, err_code,
    output data_ready
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with glitch filter, odd-parity and
// stop-bit checks, inter-edge timeout and a FIFO of received scan codes.
//   clk       system clock
//   rst       asynchronous active-low reset
//   ps2_clk   raw PS/2 clock pin (asynchronous)
//   ps2_data  raw PS/2 data pin (asynchronous)
//   rx        master side of ps2_rx_fifo_if (FIFO head, handshake, errors)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a start bit (data 0 on a strike)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the parity bit
// S_STOP   | checking stop bit and parity, pushing the byte if good
module ps2_rx_fifo #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int TIMEOUT_TICKS = CLK_HZ / 8000,
  parameter int FILTER_LEN    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_W         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_rx_fifo_if.master rx
);

  localparam int FLT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TO_W  = (TIMEOUT_TICKS > 2) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- input sync
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_s;
  logic       dat_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // ------------------------------------------------------------ glitch filter
  // The filtered clock only follows the synced pin once it has disagreed for
  // FILTER_LEN consecutive samples; any agreeing sample restarts the count.
  logic             filt;
  logic             filt_prev;
  logic [FLT_W-1:0] flt_cnt;
  logic             strike;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt      <= 1'b1;
      filt_prev <= 1'b1;
      flt_cnt   <= '0;
    end else begin
      filt_prev <= filt;
      if (clk_s == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        filt    <= clk_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign strike = filt_prev & ~filt;

  // --------------------------------------------------------------------- FSM
  state_t          state;
  state_t          state_nxt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            parity_bit;
  logic [TO_W-1:0] to_cnt;

  logic start;
  logic shift_en;
  logic par_en;
  logic frame_good;
  logic frame_perr;
  logic frame_ferr;
  logic tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    frame_good = 1'b0;
    frame_perr = 1'b0;
    frame_ferr = 1'b0;
    tmo        = 1'b0;
    case (state)
      S_IDLE: begin
        if (strike && !dat_s) begin
          start     = 1'b1;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (strike) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (strike) begin
          par_en    = 1'b1;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (strike) begin
          state_nxt = S_IDLE;
          // Framing takes precedence so a frame reports at most one error.
          if (!dat_s)                         frame_ferr = 1'b1;
          else if (!(^{shift_reg, parity_bit})) frame_perr = 1'b1;
          else                                frame_good = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE && !strike && to_cnt == TO_LAST) begin
      tmo       = 1'b1;
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
    end else begin
      if (start) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end
      if (shift_en) begin
        shift_reg <= {dat_s, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (par_en) parity_bit <= dat_s;
      if (state == S_IDLE || strike || tmo) to_cnt <= '0;
      else                                  to_cnt <= to_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------- FIFO
  // The good-frame decision is registered, so the write lands one cycle
  // after the stop-bit strike.
  logic             push_req;
  logic [7:0]       push_data;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             ovf;

  assign full    = (count == CNT_FULL);
  assign pop     = (count != '0) && rx.data_ready;
  assign push_ok = push_req && (!full || pop);
  assign ovf     = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_req  <= 1'b0;
      push_data <= '0;
    end else begin
      push_req  <= frame_good;
      push_data <= shift_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ------------------------------------------------------------------ errors
  logic       err_stb_q;
  logic [1:0] err_code_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_stb_q  <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      err_stb_q <= ovf | frame_ferr | frame_perr | tmo;
      if (ovf)             err_code_q <= 2'd3;
      else if (frame_ferr) err_code_q <= 2'd1;
      else if (frame_perr) err_code_q <= 2'd0;
      else if (tmo)        err_code_q <= 2'd2;
    end
  end

  assign rx.data_out   = mem[rd_ptr];
  assign rx.data_valid = (count != '0);
  assign rx.fifo_count = count;
  assign rx.err_stb    = err_stb_q;
  assign rx.err_code   = err_code_q;

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver. It is the successor to the single-byte receiver, and adds a glitch filter, odd-parity and stop-bit checking, an inter-edge timeout, and a FIFO of received scan codes. The FIFO output uses a valid/ready handshake. The block sits between the PS/2 connector pins and the keyboard/mouse decoder logic, all in the system clock domain.

Parameters:
CLK_HZ, 100000000, system clock frequency; informational only, used to size the defaults.
TIMEOUT_TICKS, 12500, clk cycles allowed between filtered ps2_clk edges while a frame is in progress (125 us at 100 MHz).
FILTER_LEN, 8, consecutive identical synced samples required before the filtered ps2_clk changes; must be at least 2.
FIFO_DEPTH, 4, number of frames buffered; must be a power of 2, at least 2.
CNT_W, $clog2(FIFO_DEPTH+1), width of fifo_count.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
ps2_data  in  1  raw PS/2 data pin (asynchronous)
data_out  out  8  byte at the FIFO head
data_valid  out  1  FIFO not empty
data_ready  in  1  consumer accepts data_out this cycle
fifo_count  out  CNT_W  number of frames currently stored
err_stb  out  1  one-cycle error strobe
err_code  out  2  error type, valid while err_stb is high: 0 parity, 1 framing, 2 timeout, 3 overflow

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; all counters, shift register and FIFO pointers clear.
  - Outputs: data_out=0, data_valid=0, fifo_count=0, err_stb=0, err_code=0.
  - Filtered ps2_clk and both sync chains reset to 1.
  - Reset mid-frame discards the partial frame and all buffered frames.
- Input conditioning:
  - 2-FF synchronisers on ps2_clk and ps2_data.
  - Filter counter: the filtered clock takes the synced value after FILTER_LEN consecutive equal samples. Shorter pulses are ignored.
  - A falling edge on the filtered clock produces a one-cycle sample strike. The strike samples the synced ps2_data in that same cycle.
- FSM, advancing only on sample strikes unless noted:
  - IDLE: data=0 -> DATA, with bit_cnt=0 and the timeout counter cleared. data=1 -> remain in IDLE, no error.
  - DATA: shift data in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: always -> IDLE.
    - Stop bit 0: framing error (code 1).
    - Else, if popcount(byte)+parity is even: parity error (code 0).
    - Else: push the byte to the FIFO.
    - If framing and parity errors occur together, report framing only.
- Timeout:
  - The counter runs in every state except IDLE and clears on each strike.
  - When it reaches TIMEOUT_TICKS: FSM -> IDLE, err_stb with code 2, partial byte discarded.
- FIFO:
  - First-word fall-through: data_out always shows the head entry; data_valid = (fifo_count != 0).
  - A pop happens when data_valid && data_ready.
  - Push while full with no pop in the same cycle: the new byte is dropped, err_stb with code 3, stored contents unchanged.
  - Push and pop in the same cycle while full: both succeed, no error, count unchanged.
  - Push and pop in the same cycle while empty: the push lands and data_valid rises next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency:
  - The push is written one cycle after the stop-bit strike, and data_valid/fifo_count update at that clock edge.
  - From the ps2_clk pin falling edge to the strike is a fixed FILTER_LEN+3 cycles (±1 for pin phase).
- err_stb is high for exactly one cycle per event; at most one error per frame.

Test Plan:
- Frame 0xEE (start 0, bits 0,1,1,1,0,1,1,1, parity 1, stop 1), 50 us half-period, data_ready=0 -> data_valid=1, data_out=0xEE, fifo_count=1, no err_stb.
- Same frame with parity 0 -> err_stb once with err_code=0, fifo_count stays 0. Repeat with stop 0 -> err_code=1.
- Start bit, one data bit, then ps2_clk held low 125 us -> err_stb with err_code=2 about 12500 cycles after the last strike, FSM in IDLE. The next valid frame 0x1C is received correctly.
- FIFO_DEPTH=4, five frames 0x01..0x05 with data_ready=0 -> fifo_count=4 and err_code=3 on the 5th. Then data_ready=1 reads out 0x01,0x02,0x03,0x04 and data_valid falls.
- Glitches: 3-cycle low pulses on ps2_clk during IDLE and mid-DATA with FILTER_LEN=8 -> no strikes; the frame 0xA5 (parity 1) is received unchanged.
- rst low for 2 cycles after 4 data bits, with 2 frames buffered -> all outputs return to reset values at once. A subsequent frame 0xA5 gives fifo_count=1, data_out=0xA5.
